// File: rtl/pic_priority_arbiter.sv
// 8259-style interrupt arbiter: IRR/ISR bookkeeping, rotating priority,
// fully nested request resolution, acknowledge grant and EOI retirement.
module pic_priority_arbiter #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [7:0] irq_in,
  input  logic       level_mode,
  input  logic [7:0] int_mask,
  input  logic       ack_latch,
  input  logic       ack_done,
  input  logic       auto_eoi,
  input  logic       eoi_nonspecific,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic       set_priority,
  input  logic [2:0] priority_level,
  output logic       int_req,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] ack_level
);

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LEVEL_W    = 3;

  typedef struct packed {
    logic               found;
    logic [LEVEL_W-1:0] level;
  } pick_t;

  // Highest set bit of vec in the order lowest+1 .. lowest (wrapping).
  function automatic pick_t pick_highest(input logic [NUM_LEVELS-1:0] vec,
                                         input logic [LEVEL_W-1:0]    lowest);
    pick_t              p;
    logic [LEVEL_W-1:0] idx;
    p = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = LEVEL_W'(lowest + LEVEL_W'(k));
      if (vec[idx] && !p.found) begin
        p.found = 1'b1;
        p.level = idx;
      end
    end
    return p;
  endfunction

  // Rank 0 is the highest priority level, rank 7 is the lowest-priority pointer.
  function automatic logic [LEVEL_W-1:0] rank_of(input logic [LEVEL_W-1:0] level,
                                                 input logic [LEVEL_W-1:0] lowest);
    return LEVEL_W'(level - lowest - LEVEL_W'(1));
  endfunction

  logic [NUM_LEVELS-1:0] irq_prev;
  logic [LEVEL_W-1:0]    lp;
  logic                  ack_granted;

  logic [NUM_LEVELS-1:0] cand;
  pick_t                 pend;
  pick_t                 svc;
  logic [NUM_LEVELS-1:0] irr_n;
  logic [NUM_LEVELS-1:0] isr_n;
  logic [LEVEL_W-1:0]    lp_n;
  logic [LEVEL_W-1:0]    ack_level_n;
  logic                  ack_granted_n;
  logic                  int_req_n;

  // Priority resolution of pending requests and in-service levels.
  always_comb begin
    cand = irr & ~int_mask;
    pend = pick_highest(cand, lp);
    svc  = pick_highest(isr, lp);
  end

  // One-hot of the highest in-service level under the current rotation.
  always_comb begin
    highest_level_in_service = '0;
    if (svc.found) begin
      highest_level_in_service = NUM_LEVELS'(1) << svc.level;
    end
  end

  // Next-state for IRR, ISR, rotation pointer, grant record and INT request.
  always_comb begin
    if (level_mode) begin
      irr_n = irq_in;
    end else begin
      irr_n = (irr | (irq_in & ~irq_prev)) & irq_in;
    end
    isr_n         = isr;
    lp_n          = lp;
    ack_level_n   = ack_level;
    ack_granted_n = ack_granted;

    // End of acknowledge: optional automatic EOI of the granted level.
    if (ack_done) begin
      if (auto_eoi && ack_granted) begin
        isr_n[ack_level] = 1'b0;
        if (rotate_on_eoi) begin
          lp_n = ack_level;
        end
      end
      ack_granted_n = 1'b0;
    end

    // Explicit EOI; specific takes precedence over non-specific.
    if (eoi_specific) begin
      isr_n[eoi_level] = 1'b0;
      if (rotate_on_eoi) begin
        lp_n = eoi_level;
      end
    end else if (eoi_nonspecific && svc.found) begin
      isr_n[svc.level] = 1'b0;
      if (rotate_on_eoi) begin
        lp_n = svc.level;
      end
    end

    // Grant is applied after the clears so a same-bit set survives.
    if (ack_latch) begin
      if (pend.found) begin
        isr_n[pend.level] = 1'b1;
        irr_n[pend.level] = 1'b0;
        ack_level_n       = pend.level;
        ack_granted_n     = 1'b1;
      end else begin
        ack_level_n   = SPURIOUS_LEVEL;
        ack_granted_n = 1'b0;
      end
    end

    if (set_priority) begin
      lp_n = priority_level;
    end

    // Fully nested: only a strictly higher pending level interrupts service.
    int_req_n = pend.found &&
                (!svc.found || (rank_of(pend.level, lp) < rank_of(svc.level, lp)));
  end

  // State registers; init re-initialises exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      irr         <= '0;
      isr         <= '0;
      lp          <= 3'd7;
      ack_level   <= '0;
      ack_granted <= 1'b0;
      int_req     <= 1'b0;
      irq_prev    <= '0;
    end else begin
      irr         <= irr_n;
      isr         <= isr_n;
      lp          <= lp_n;
      ack_level   <= ack_level_n;
      ack_granted <= ack_granted_n;
      int_req     <= int_req_n;
      irq_prev    <= irq_in;
    end
  end

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// Directed bench for pic_priority_arbiter with a cycle-level reference model.
module tb_pic_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [7:0] irq_in = '0;
  logic       level_mode = 1'b0;
  logic [7:0] int_mask = '0;
  logic       ack_latch = 1'b0;
  logic       ack_done = 1'b0;
  logic       auto_eoi = 1'b0;
  logic       eoi_nonspecific = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = '0;
  logic       rotate_on_eoi = 1'b0;
  logic       set_priority = 1'b0;
  logic [2:0] priority_level = '0;
  logic       int_req;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] highest_level_in_service;
  logic [2:0] ack_level;

  int n_vec = 0;
  int n_bad = 0;

  pic_priority_arbiter #(.SPURIOUS_LEVEL(3'd7)) dut (
    .clk(clk), .reset(reset), .init(init), .irq_in(irq_in),
    .level_mode(level_mode), .int_mask(int_mask), .ack_latch(ack_latch),
    .ack_done(ack_done), .auto_eoi(auto_eoi), .eoi_nonspecific(eoi_nonspecific),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .rotate_on_eoi(rotate_on_eoi),
    .set_priority(set_priority), .priority_level(priority_level),
    .int_req(int_req), .irr(irr), .isr(isr),
    .highest_level_in_service(highest_level_in_service), .ack_level(ack_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain bit arrays and integer priority arithmetic.
  bit [7:0] m_irr = '0, m_isr = '0, m_prev = '0;
  int       m_lp = 7, m_ack_level = 0;
  bit       m_int_req = 1'b0, m_ack_good = 1'b0;

  function automatic int top_of(input bit [7:0] v, input int lp);
    for (int r = 0; r < 8; r++) begin
      int l;
      l = (lp + 1 + r) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic int prio(input int l, input int lp);
    return (l - lp + 7) % 8;
  endfunction

  always @(posedge clk) begin : model_b
    bit [7:0] cand, n_irr, n_isr;
    int pend, svc, n_lp, n_al;
    bit n_good, n_req;
    if (reset || init) begin
      m_irr = '0; m_isr = '0; m_prev = '0; m_lp = 7;
      m_ack_level = 0; m_int_req = 1'b0; m_ack_good = 1'b0;
    end else begin
      cand  = m_irr & ~int_mask;
      pend  = top_of(cand, m_lp);
      svc   = top_of(m_isr, m_lp);
      n_req = (pend >= 0) && (svc < 0 || prio(pend, m_lp) < prio(svc, m_lp));
      for (int i = 0; i < 8; i++) begin
        if (level_mode)       n_irr[i] = irq_in[i];
        else if (!irq_in[i])  n_irr[i] = 1'b0;
        else if (!m_prev[i])  n_irr[i] = 1'b1;
        else                  n_irr[i] = m_irr[i];
      end
      n_isr = m_isr; n_lp = m_lp; n_al = m_ack_level; n_good = m_ack_good;
      if (ack_done) begin
        if (auto_eoi && m_ack_good) begin
          n_isr[m_ack_level] = 1'b0;
          if (rotate_on_eoi) n_lp = m_ack_level;
        end
        n_good = 1'b0;
      end
      if (eoi_specific) begin
        n_isr[eoi_level] = 1'b0;
        if (rotate_on_eoi) n_lp = int'(eoi_level);
      end else if (eoi_nonspecific && svc >= 0) begin
        n_isr[svc] = 1'b0;
        if (rotate_on_eoi) n_lp = svc;
      end
      if (ack_latch) begin
        if (pend >= 0) begin
          n_isr[pend] = 1'b1; n_irr[pend] = 1'b0; n_al = pend; n_good = 1'b1;
        end else begin
          n_al = 7; n_good = 1'b0;
        end
      end
      if (set_priority) n_lp = int'(priority_level);
      m_irr = n_irr; m_isr = n_isr; m_lp = n_lp; m_ack_level = n_al;
      m_ack_good = n_good; m_int_req = n_req; m_prev = irq_in;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    int hl;
    bit [7:0] hl_exp;
    #2;
    hl = top_of(m_isr, m_lp);
    hl_exp = (hl < 0) ? 8'h00 : (8'h01 << hl);
    chk("int_req", {7'b0, int_req}, {7'b0, m_int_req});
    chk("irr", irr, m_irr);
    chk("isr", isr, m_isr);
    chk("ack_level", {5'b0, ack_level}, 8'(m_ack_level));
    chk("hlis", highest_level_in_service, hl_exp);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #3; end
  endtask
  task automatic do_ack();
    ack_latch = 1'b1; cyc(); ack_latch = 1'b0;
  endtask
  task automatic do_done();
    ack_done = 1'b1; cyc(); ack_done = 1'b0;
  endtask
  task automatic do_eoi_ns();
    eoi_nonspecific = 1'b1; cyc(); eoi_nonspecific = 1'b0;
  endtask
  task automatic do_eoi_spec(input logic [2:0] l);
    eoi_specific = 1'b1; eoi_level = l; cyc(); eoi_specific = 1'b0;
  endtask
  task automatic do_setpri(input logic [2:0] l);
    set_priority = 1'b1; priority_level = l; cyc(); set_priority = 1'b0;
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_int_req", {7'b0, int_req}, 8'h00);
    chk("rst_ack_level", {5'b0, ack_level}, 8'h00);

    // Basic edge-triggered request and grant.
    irq_in = 8'h08; cyc();
    chk("t1_irr", irr, 8'h08);
    chk("t1_req_early", {7'b0, int_req}, 8'h00);
    cyc();
    chk("t1_req", {7'b0, int_req}, 8'h01);
    do_ack();
    chk("t1_isr", isr, 8'h08);
    chk("t1_irr_clr", irr, 8'h00);
    chk("t1_ack_level", {5'b0, ack_level}, 8'h03);
    cyc();
    chk("t1_req_drop", {7'b0, int_req}, 8'h00);
    irq_in = 8'h00; do_eoi_spec(3'd3); cyc();

    // Fully nested blocking and pre-emption.
    irq_in = 8'h20; cyc(2); do_ack();
    irq_in = 8'h60; cyc(2);
    chk("t2_ir6_blocked", {7'b0, int_req}, 8'h00);
    irq_in = 8'h64; cyc(2);
    chk("t2_ir2_req", {7'b0, int_req}, 8'h01);
    do_ack();
    chk("t2_isr", isr, 8'h24);
    chk("t2_hlis", highest_level_in_service, 8'h04);

    // Non-specific EOI without and with rotation.
    do_eoi_ns();
    chk("t3_isr", isr, 8'h20);
    irq_in = 8'h60; cyc(); irq_in = 8'h64; cyc(2); do_ack();
    chk("t3_isr_again", isr, 8'h24);
    rotate_on_eoi = 1'b1; do_eoi_ns(); rotate_on_eoi = 1'b0;
    chk("t3_isr_rot", isr, 8'h20);
    do_eoi_spec(3'd5);
    irq_in = 8'h00; cyc();
    irq_in = 8'h0A; cyc(2); do_ack();
    chk("t3_ir3_first", {5'b0, ack_level}, 8'h03);
    cyc();
    chk("t3_ir1_blocked", {7'b0, int_req}, 8'h00);
    do_eoi_spec(3'd3); irq_in = 8'h00; cyc(2);

    // Auto EOI with rotation.
    auto_eoi = 1'b1; rotate_on_eoi = 1'b1;
    irq_in = 8'h10; cyc(2); do_ack();
    chk("t4_isr", isr, 8'h10);
    do_done();
    chk("t4_isr_auto", isr, 8'h00);
    irq_in = 8'h00; cyc();
    irq_in = 8'h21; cyc(2); do_ack();
    chk("t4_ir5_wins", {5'b0, ack_level}, 8'h05);
    do_done();
    auto_eoi = 1'b0; rotate_on_eoi = 1'b0;
    irq_in = 8'h00; do_setpri(3'd7); cyc();

    // Spurious acknowledge after masking.
    irq_in = 8'h02; cyc(); int_mask = 8'h02; cyc(); do_ack();
    chk("t5_spur_level", {5'b0, ack_level}, 8'h07);
    chk("t5_spur_isr", isr, 8'h00);
    chk("t5_irr_kept", irr, 8'h02);
    chk("t5_req", {7'b0, int_req}, 8'h00);
    auto_eoi = 1'b1; rotate_on_eoi = 1'b1; do_done();
    auto_eoi = 1'b0; rotate_on_eoi = 1'b0;
    int_mask = 8'h00; irq_in = 8'h00; cyc(2);

    // Same-cycle EOI and grant.
    irq_in = 8'h01; cyc(2); do_ack();
    irq_in = 8'h03; cyc(2);
    eoi_nonspecific = 1'b1; ack_latch = 1'b1; cyc();
    eoi_nonspecific = 1'b0; ack_latch = 1'b0;
    chk("t5b_isr", isr, 8'h02);
    do_eoi_spec(3'd1); irq_in = 8'h00; cyc(2);

    // init mid-service with a coincident acknowledge.
    do_setpri(3'd3);
    irq_in = 8'h01; cyc(2); do_ack();
    irq_in = 8'h81; cyc(2);
    chk("t6_ir7_req", {7'b0, int_req}, 8'h01);
    do_ack();
    chk("t6_isr", isr, 8'h81);
    chk("t6_hlis", highest_level_in_service, 8'h80);
    irq_in = 8'h91; cyc();
    init = 1'b1; ack_latch = 1'b1; cyc(); init = 1'b0; ack_latch = 1'b0;
    chk("t6_irr", irr, 8'h00);
    chk("t6_isr_clr", isr, 8'h00);
    chk("t6_req", {7'b0, int_req}, 8'h00);
    cyc();
    irq_in = 8'h00; cyc(2);

    // Level-triggered requests follow the pin.
    level_mode = 1'b1;
    irq_in = 8'h04; cyc();
    chk("t7_irr", irr, 8'h04);
    cyc(); do_ack();
    chk("t7_irr_ack", irr, 8'h00);
    cyc();
    chk("t7_irr_back", irr, 8'h04);
    irq_in = 8'h00; do_eoi_spec(3'd2); cyc();
    level_mode = 1'b0; cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
